amplitude_restorer: RTL
=======================

AMPLITUDE_RESTORER -- requirements
Module: amplitude_restorer

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: in_data  input  8  signed two's-complement attenuated sample.
REQ-004 SHALL provide: in_valid  input  1  in_data valid.
REQ-005 SHALL provide: in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL provide: sel  input  2  gain code, shift-left amount 0..3.
REQ-007 SHALL provide: sel_load  input  1  one-cycle strobe that captures sel into active_sel.
REQ-008 SHALL provide: out_data  output  8  signed restored sample.
REQ-009 SHALL provide: out_sat  output  1  out_data was clipped; aligned with out_data.
REQ-010 SHALL provide: out_valid  output  1  out_data valid.
REQ-011 SHALL provide: out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL provide: sat_count  output  8  number of clipped samples transferred out.
REQ-013 SHALL provide: clr_count  input  1  synchronous clear of sat_count.

Function
REQ-014 SHALL implement the inverse of the team's arithmetic-right-shift attenuator: result = in_data * 2^active_sel, signed.
REQ-015 SHALL saturate results above 127 to 0x7F and results below -128 to 0x80, setting out_sat=1; out_sat=0 otherwise, including an exact -128 result.
REQ-016 SHALL form the full-precision product in at least 11 signed bits before the saturation decision.
REQ-017 SHALL use a two-stage pipeline: S1 registers the shifted value and S2 registers the saturated value plus the flag; latency is 2 cycles from the in_valid&&in_ready edge to out_valid, with no stall.
REQ-018 SHALL use valid/ready on both sides; a transfer occurs on any cycle where valid&&ready.
REQ-019 SHALL drive stage readiness as ready_S2 = !out_valid || out_ready and ready_S1 = !S1_valid || ready_S2; in_ready = ready_S1, combinational.
REQ-020 SHALL hold out_data and out_sat stable while out_valid=1 and out_ready=0.
REQ-021 SHALL never drop, duplicate or reorder samples; at most 2 samples are in flight.
REQ-022 SHALL sustain 1 sample/cycle when out_ready is held at 1.
REQ-023 SHALL load active_sel from sel on sel_load; the new value applies to samples accepted on later cycles.
REQ-024 SHALL process a sample accepted in the same cycle as sel_load with the old active_sel.
REQ-025 SHALL tag each sample with the active_sel value in force at acceptance; a change of active_sel SHALL NOT affect samples already in flight.
REQ-026 SHALL increment sat_count on each output transfer with out_sat=1.
REQ-027 SHALL hold sat_count at 255 once reached (saturating, no wrap).
REQ-028 SHALL give clr_count priority over an increment in the same cycle, so sat_count becomes 0.
REQ-029 SHALL ignore in_data while in_valid=0 and ignore sel while sel_load=0.

Reset
REQ-030 SHALL clear, on rst_n low and independent of clk: S1_valid=0, out_valid=0, out_data=0x00, out_sat=0, active_sel=0, sat_count=0.
REQ-031 SHALL, on reset mid-stream, discard all in-flight samples; in_ready reads 1 while rst_n is low.
REQ-032 SHALL accept the first sample on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: reset, sel_load sel=0, in 0x45, out_ready=1 -> out_data 0x45, out_sat 0, out_valid 2 cycles after acceptance.
REQ-034 SHALL cover: sel_load sel=2, in 0x1F then 0x20 -> 0x7C sat 0, then 0x7F sat 1, sat_count=1.
REQ-035 SHALL cover: sel=3, in 0xF0 then 0xEF -> 0x80 sat 0, then 0x80 sat 1.
REQ-036 SHALL cover: out_ready=0 for 5 cycles while pushing 0x01,0x02,0x03 at sel=1 -> in_ready drops after 2 accepts; release yields 0x02,0x04,0x06 in order, none lost.
REQ-037 SHALL cover: sel_load sel=1 coincident with accepting 0x10 under sel=0, next sample 0x10 -> outputs 0x10 then 0x20.
REQ-038 SHALL cover: drive sat_count to 255, one more clipped sample -> stays 255; clr_count with simultaneous clipped transfer -> 0; rst_n pulse mid-stream -> out_valid 0 immediately, active_sel 0.

Source files
------------

// File: rtl/amplitude_restorer.sv
// Two-stage gain restorer: undoes an arithmetic-right-shift attenuator by shifting left
// with saturation to signed 8 bits, behind valid/ready handshakes on both sides.
module amplitude_restorer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] sel,
    input  logic       sel_load,
    output logic [7:0] out_data,
    output logic       out_sat,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sat_count,
    input  logic       clr_count
);

    logic [1:0]         active_sel;
    logic               s1_valid;
    logic signed [10:0] s1_prod;
    logic signed [10:0] in_ext;
    logic signed [10:0] in_shifted;
    logic               ready_s1;
    logic               ready_s2;
    logic [7:0]         sat_data;
    logic               sat_flag;

    // Eleven bits hold any 8-bit sample shifted by up to 3 without loss.
    assign in_ext     = {{3{in_data[7]}}, in_data};
    assign in_shifted = in_ext <<< active_sel;

    assign ready_s2 = !out_valid || out_ready;
    assign ready_s1 = !s1_valid || ready_s2;
    assign in_ready = ready_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_sel <= 2'd0;
        end else if (sel_load) begin
            active_sel <= sel;
        end
    end

    // The gain is applied on entry, so in-flight samples keep the gain they were accepted with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
        end else if (ready_s1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod <= in_shifted;
            end
        end
    end

    always_comb begin
        sat_data = s1_prod[7:0];
        sat_flag = 1'b0;
        if (s1_prod > 11'sd127) begin
            sat_data = 8'h7F;
            sat_flag = 1'b1;
        end else if (s1_prod < -11'sd128) begin
            sat_data = 8'h80;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sat   <= 1'b0;
        end else if (ready_s2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= 8'd0;
        end else if (clr_count) begin
            sat_count <= 8'd0;
        end else if (out_valid && out_ready && out_sat && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
        end
    end

endmodule
